// File: rtl/ttt_pkg.sv
// Shared types, constants and helpers for the tic-tac-toe referee.
package ttt_pkg;

  // ST_INIT is the post-reset holding state; play begins on the first edge after release.
  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_CHECK = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  // Bit positions inside the 10-bit gameover vector.
  localparam int GO_ROW0  = 0;
  localparam int GO_ROW1  = 1;
  localparam int GO_ROW2  = 2;
  localparam int GO_COL0  = 3;
  localparam int GO_COL1  = 4;
  localparam int GO_COL2  = 5;
  localparam int GO_DIAG0 = 6;
  localparam int GO_DIAG1 = 7;
  localparam int GO_DRAW  = 8;
  localparam int GO_OVER  = 9;

  // Cell masks of the eight lines, ordered to match gameover[7:0]; bit = row*3+col.
  localparam logic [8:0] LINE_MASK [8] = '{
    9'b000_000_111,  // row 0
    9'b000_111_000,  // row 1
    9'b111_000_000,  // row 2
    9'b001_001_001,  // col 0
    9'b010_010_010,  // col 1
    9'b100_100_100,  // col 2
    9'b100_010_001,  // diagonal 0,4,8
    9'b001_010_100   // anti-diagonal 2,4,6
  };

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;

  // {row,col} address to linear cell index row*3+col.
  function automatic logic [3:0] addr_to_idx(input logic [3:0] addr);
    return ({2'b00, addr[3:2]} * 4'd3) + {2'b00, addr[1:0]};
  endfunction

  // Address lies on the 3x3 board: column 3 and row 3 do not exist.
  function automatic logic addr_legal(input logic [3:0] addr);
    return (addr[1:0] != 2'd3) && (addr <= 4'hA);
  endfunction

endpackage

// File: rtl/ttt_line_eval.sv
// Combinational line evaluator: which of the eight lines the mover owns, and
// whether the board has no empty cell left.
module ttt_line_eval
  import ttt_pkg::*;
(
  input  logic [8:0] bitmap,
  input  logic [8:0] occupied,
  output logic [7:0] lines,
  output logic       full
);

  // A line is complete when every cell of its mask is set in the mover's bitmap.
  // NOTE: every output gets a value on every path, so no latch can be inferred.
  always_comb begin
    lines = '0;
    for (int l = 0; l < 8; l++) begin
      lines[l] = ((bitmap & LINE_MASK[l]) == LINE_MASK[l]);
    end
    full = &occupied;
  end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe turn sequencer and referee: move handshake, legality checks,
// board bitmaps, win/draw detection and an optional per-turn timeout.
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter int TURN_TIMEOUT = 100_000_000,
  parameter int CNT_W        = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_addr,
  output logic       move_ready,
  output logic       move_err,
  output logic [8:0] board_x,
  output logic [8:0] board_o,
  output logic       turn,
  output logic [9:0] gameover,
  output logic [1:0] winner,
  output logic       timeout
);

  localparam logic             TIMER_EN   = (TURN_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TURN_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [8:0]       board_x_q, board_x_d;
  logic [8:0]       board_o_q, board_o_d;
  logic             turn_q, turn_d;
  logic             first_q, first_d;  // side that opened the current game
  logic [9:0]       gameover_q, gameover_d;
  logic [1:0]       winner_q, winner_d;
  logic             move_err_q, move_err_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] timer_q, timer_d;

  logic [8:0] occupied;
  logic [8:0] mover_map;
  logic [8:0] cell_mask;
  logic       cell_free;
  logic       move_ok;
  logic [7:0] lines;
  logic       full;

  assign occupied  = board_x_q | board_o_q;
  assign mover_map = turn_q ? board_o_q : board_x_q;
  assign cell_mask = 9'b1 << addr_to_idx(move_addr);
  assign cell_free = ~|(occupied & cell_mask);
  assign move_ok   = addr_legal(move_addr) && cell_free;

  ttt_line_eval u_line_eval (
    .bitmap   (mover_map),
    .occupied (occupied),
    .lines    (lines),
    .full     (full)
  );

  // Next-state logic for the game sequencer, timer and board.
  always_comb begin
    state_d    = state_q;
    board_x_d  = board_x_q;
    board_o_d  = board_o_q;
    turn_d     = turn_q;
    first_d    = first_q;
    gameover_d = gameover_q;
    winner_d   = winner_q;
    timer_d    = timer_q;
    move_err_d = 1'b0;
    timeout_d  = 1'b0;

    if (new_game) begin
      // Alternate the opening side from game to game.
      state_d    = ST_PLAY;
      board_x_d  = '0;
      board_o_d  = '0;
      gameover_d = '0;
      winner_d   = WIN_NONE;
      timer_d    = '0;
      turn_d     = ~first_q;
      first_d    = ~first_q;
    end else begin
      unique case (state_q)
        ST_INIT: state_d = ST_PLAY;

        ST_PLAY: begin
          if (move_valid) begin
            if (move_ok) begin
              if (turn_q) board_o_d = board_o_q | cell_mask;
              else        board_x_d = board_x_q | cell_mask;
              timer_d = '0;
              state_d = ST_CHECK;
            end else begin
              // A rejected move keeps the clock running; it saturates so the
              // forfeit lands on the next idle cycle instead of clashing with move_err.
              move_err_d = 1'b1;
              if (TIMER_EN && timer_q != TIMER_LAST) timer_d = timer_q + CNT_W'(1);
            end
          end else if (TIMER_EN) begin
            if (timer_q == TIMER_LAST) begin
              timeout_d = 1'b1;
              turn_d    = ~turn_q;
              timer_d   = '0;
            end else begin
              timer_d = timer_q + CNT_W'(1);
            end
          end
        end

        ST_CHECK: begin
          if (|lines) begin
            gameover_d          = '0;
            gameover_d[7:0]     = lines;
            gameover_d[GO_OVER] = 1'b1;
            winner_d            = turn_q ? WIN_O : WIN_X;
            state_d             = ST_OVER;
          end else if (full) begin
            gameover_d          = '0;
            gameover_d[GO_DRAW] = 1'b1;
            gameover_d[GO_OVER] = 1'b1;
            winner_d            = WIN_NONE;
            state_d             = ST_OVER;
          end else begin
            turn_d  = ~turn_q;
            timer_d = '0;
            state_d = ST_PLAY;
          end
        end

        ST_OVER: ;  // hold everything until new_game

        default: state_d = ST_INIT;
      endcase
    end
  end

  // State register; every output below is taken straight from a flop.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      board_x_q  <= '0;
      board_o_q  <= '0;
      turn_q     <= 1'b0;
      first_q    <= 1'b0;
      gameover_q <= '0;
      winner_q   <= WIN_NONE;
      move_err_q <= 1'b0;
      timeout_q  <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      board_x_q  <= board_x_d;
      board_o_q  <= board_o_d;
      turn_q     <= turn_d;
      first_q    <= first_d;
      gameover_q <= gameover_d;
      winner_q   <= winner_d;
      move_err_q <= move_err_d;
      timeout_q  <= timeout_d;
      timer_q    <= timer_d;
    end
  end

  assign move_ready = (state_q == ST_PLAY);
  assign move_err   = move_err_q;
  assign timeout    = timeout_q;
  assign board_x    = board_x_q;
  assign board_o    = board_o_q;
  assign turn       = turn_q;
  assign gameover   = gameover_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Self-checking bench for ttt_game_ctrl: directed games plus random play
// compared against a cell-array model of the rules.
module tb_ttt_game_ctrl;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       new_game;
  logic       move_valid;
  logic [3:0] move_addr;
  logic       move_ready;
  logic       move_err;
  logic [8:0] board_x;
  logic [8:0] board_o;
  logic       turn;
  logic [9:0] gameover;
  logic [1:0] winner;
  logic       timeout;

  ttt_game_ctrl #(.TURN_TIMEOUT(TO), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .new_game   (new_game),
    .move_valid (move_valid),
    .move_addr  (move_addr),
    .move_ready (move_ready),
    .move_err   (move_err),
    .board_x    (board_x),
    .board_o    (board_o),
    .turn       (turn),
    .gameover   (gameover),
    .winner     (winner),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cell contents 0 empty, 1 X, 2 O.
  int         cells [9];
  int         turn_m, first_m, over_m, idle_m, winner_m;
  logic [9:0] go_m;
  int         lines_t [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8},
                                 '{0,3,6}, '{1,4,7}, '{2,5,8},
                                 '{0,4,8}, '{2,4,6}};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] bmap(input int p);
    logic [8:0] m;
    m = '0;
    for (int i = 0; i < 9; i++) if (cells[i] == p) m[i] = 1'b1;
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 9; i++) cells[i] = 0;
    over_m = 0; idle_m = 0; go_m = '0; winner_m = 0;
  endtask

  task automatic chk_board(input string tag);
    chk({tag, " board_x"}, 32'(board_x), 32'(bmap(1)));
    chk({tag, " board_o"}, 32'(board_o), 32'(bmap(2)));
  endtask

  // Offer one move for a single cycle and check the full response.
  task automatic do_move(input logic [3:0] a);
    int  ai, idx, p, nfull;
    bit  legal;
    logic [9:0] go;
    ai = int'(a);
    idx = (ai / 4) * 3 + (ai % 4);
    legal = 0;
    if ((ai % 4) != 3 && ai <= 10) legal = (cells[idx] == 0);
    move_valid = 1'b1; move_addr = a;
    step();
    move_valid = 1'b0;
    if (over_m != 0) begin
      chk("over move_err", 32'(move_err), 0);
      chk_board("over");
      chk("over ready", 32'(move_ready), 0);
      return;
    end
    chk("timeout on move", 32'(timeout), 0);
    if (!legal) begin
      idle_m++;
      chk("illegal move_err", 32'(move_err), 1);
      chk_board("illegal");
      chk("illegal turn", 32'(turn), 32'(turn_m));
      chk("illegal ready", 32'(move_ready), 1);
      return;
    end
    cells[idx] = turn_m + 1;
    chk("legal move_err", 32'(move_err), 0);
    chk_board("accept");
    chk("check ready", 32'(move_ready), 0);
    step();
    p = turn_m + 1;
    go = '0;
    for (int l = 0; l < 8; l++)
      if (cells[lines_t[l][0]] == p && cells[lines_t[l][1]] == p && cells[lines_t[l][2]] == p)
        go[l] = 1'b1;
    nfull = 0;
    for (int i = 0; i < 9; i++) if (cells[i] != 0) nfull++;
    if (go != 0) begin
      go[9] = 1'b1; winner_m = p; over_m = 1;
    end else if (nfull == 9) begin
      go = 10'h300; winner_m = 0; over_m = 1;
    end else begin
      turn_m ^= 1;
    end
    go_m = go; idle_m = 0;
    chk("gameover", 32'(gameover), 32'(go_m));
    chk("winner", 32'(winner), 32'(winner_m));
    chk("turn", 32'(turn), 32'(turn_m));
    chk("ready after check", 32'(move_ready), over_m ? 0 : 1);
  endtask

  task automatic idle_cycle();
    step();
    if (over_m == 0) begin
      idle_m++;
      if (idle_m == TO) begin
        chk("timeout pulse", 32'(timeout), 1);
        turn_m ^= 1; idle_m = 0;
      end else begin
        chk("no timeout", 32'(timeout), 0);
      end
      chk("idle turn", 32'(turn), 32'(turn_m));
    end
  endtask

  task automatic do_new_game(input bit with_move, input logic [3:0] a);
    new_game = 1'b1; move_valid = with_move; move_addr = a;
    step();
    new_game = 1'b0; move_valid = 1'b0;
    model_clear();
    first_m ^= 1; turn_m = first_m;
    chk_board("new_game");
    chk("ng gameover", 32'(gameover), 0);
    chk("ng winner", 32'(winner), 0);
    chk("ng turn", 32'(turn), 32'(turn_m));
    chk("ng ready", 32'(move_ready), 1);
    chk("ng move_err", 32'(move_err), 0);
  endtask

  task automatic start_x_game();
    do_new_game(0, 4'h0);
    if (turn_m != 0) do_new_game(0, 4'h0);
  endtask

  task automatic play_seq(input logic [3:0] seq [$]);
    foreach (seq[i]) do_move(seq[i]);
  endtask

  initial begin
    logic [3:0] q_addr [$];
    int empt [$];
    int k, idx;

    rst_n = 1'b0; new_game = 1'b0; move_valid = 1'b0; move_addr = '0;
    model_clear(); turn_m = 0; first_m = 0;

    // Reset state
    #12;
    chk("rst board_x", 32'(board_x), 0);
    chk("rst board_o", 32'(board_o), 0);
    chk("rst gameover", 32'(gameover), 0);
    chk("rst winner", 32'(winner), 0);
    chk("rst turn", 32'(turn), 0);
    chk("rst ready", 32'(move_ready), 0);
    chk("rst err/timeout", 32'({move_err, timeout}), 0);
    rst_n = 1'b1;
    step();
    chk("ready after reset", 32'(move_ready), 1);

    // X wins row 0
    q_addr = '{4'h0, 4'h5, 4'h1, 4'h6, 4'h2};
    play_seq(q_addr);
    chk("row0 gameover", 32'(gameover), 32'h201);
    chk("row0 winner", 32'(winner), 1);
    chk("row0 board_x", 32'(board_x), 32'h007);

    // Occupied and off-board cells
    start_x_game();
    do_move(4'h6);
    do_move(4'h6); do_move(4'h3); do_move(4'hB);
    chk("illegal turn held", 32'(turn), 1);
    chk("illegal board_o", 32'(board_o), 0);

    // Draw
    start_x_game();
    q_addr = '{4'h0, 4'h1, 4'h2, 4'h5, 4'h4, 4'h6, 4'h9, 4'h8, 4'hA};
    play_seq(q_addr);
    chk("draw gameover", 32'(gameover), 32'h300);
    chk("draw winner", 32'(winner), 0);

    // Column 1 plus diagonal on the final move (cell 4 = addr 5)
    start_x_game();
    q_addr = '{4'h0, 4'h2, 4'h1, 4'h4, 4'h9, 4'h6, 4'hA, 4'h8, 4'h5};
    play_seq(q_addr);
    chk("double gameover", 32'(gameover), 32'h250);
    chk("double winner", 32'(winner), 1);

    // OVER ignores moves; new_game wins over a simultaneous move
    do_move(4'h8);
    do_new_game(1, 4'h0);
    chk("ng after over turn", 32'(turn), 1);

    // Timeout after 8 idle cycles, then a move on the 8th cycle prevents it
    for (int i = 0; i < TO; i++) idle_cycle();
    chk("timeout flipped turn", 32'(turn), 0);
    idle_cycle();
    for (int i = 0; i < TO - 2; i++) idle_cycle();
    do_move(4'h5);
    for (int i = 0; i < TO + 1; i++) idle_cycle();

    // Random play against the model
    for (int n = 0; n < 80; n++) begin
      if (over_m != 0) begin
        do_new_game(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end else begin
        k = $urandom_range(0, 2);
        if (idle_m + k <= 5) for (int i = 0; i < k; i++) idle_cycle();
        if (idle_m >= 5 || $urandom_range(0, 3) != 0) begin
          empt.delete();
          for (int i = 0; i < 9; i++) if (cells[i] == 0) empt.push_back(i);
          idx = empt[$urandom_range(0, empt.size() - 1)];
          do_move(4'((idx / 3) * 4 + (idx % 3)));
        end else begin
          do_move(4'($urandom_range(0, 15)));
        end
      end
    end

    // Asynchronous reset while the controller is in CHECK
    if (over_m != 0) do_new_game(0, 4'h0);
    empt.delete();
    for (int i = 0; i < 9; i++) if (cells[i] == 0) empt.push_back(i);
    idx = empt[0];
    move_valid = 1'b1; move_addr = 4'((idx / 3) * 4 + (idx % 3));
    step();
    move_valid = 1'b0;
    chk("pre-reset in check", 32'(move_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst boards", 32'({board_x, board_o}), 0);
    chk("async rst gameover", 32'(gameover), 0);
    chk("async rst misc", 32'({winner, turn, move_ready, move_err, timeout}), 0);
    #2 rst_n = 1'b1;
    model_clear(); turn_m = 0; first_m = 0;
    step();
    chk("ready after async rst", 32'(move_ready), 1);
    do_move(4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard bound on run time in case the DUT wedges.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ttt_game_ctrl.md
Name: ttt_game_ctrl

Overview:
Turn sequencer and referee for the tic-tac-toe board. It accepts player moves through a valid/ready handshake, validates them, and stores board state as one X bitmap and one O bitmap. After each placement it evaluates the eight winning lines and drives the 10-bit gameover vector consumed by the winning-line colour decoder and VGA path. It also enforces an optional per-turn timeout.

Parameters:
TURN_TIMEOUT, 100_000_000, clk cycles allowed per turn before the turn is forfeited; 0 disables the timer.
CNT_W, 27, width of the turn timer; must satisfy 2^CNT_W > TURN_TIMEOUT.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
new_game  input  1  single-cycle request to clear the board and start a new game
move_valid  input  1  a move is presented on move_addr
move_addr  input  4  cell address {row[1:0],col[1:0]}; legal values are 0-2, 4-6 and 8-A
move_ready  output  1  controller can accept a move this cycle
move_err  output  1  one-cycle pulse: the offered move was rejected
board_x  output  9  X occupancy; bit index = row*3+col
board_o  output  9  O occupancy; same indexing as board_x
turn  output  1  side to move: 0 = X, 1 = O
gameover  output  10  [0..2] rows 0..2; [3..5] cols 0..2; [6] diagonal cells 0,4,8; [7] anti-diagonal cells 2,4,6; [8] draw; [9] game over
winner  output  2  00 none, 01 X, 10 O; valid while gameover[9]=1
timeout  output  1  one-cycle pulse when a turn is forfeited

Behaviour:
- Reset (async, rst_n=0) state:
  - board_x, board_o, gameover, winner and timer all 0.
  - turn=0, move_err=0, timeout=0, move_ready=0.
  - State = PLAY from the first clk edge after release.
- States are PLAY, CHECK and OVER.
- PLAY:
  - move_ready=1.
  - A move is accepted when move_valid & move_ready.
  - Legal move (addr[1:0]!=3, addr<=0xA, cell empty in both bitmaps): set the current player's bit on that edge, go to CHECK.
  - Illegal move: move_err=1 for one cycle, board and turn unchanged, stay in PLAY, timer not reset.
- CHECK:
  - move_ready=0; lasts exactly 1 cycle.
  - Evaluate the eight lines over the mover's bitmap only.
  - If any line is complete, load gameover[7:0] with all completed lines (multiple allowed, e.g. row+col), set gameover[9]=1, set winner to the mover, go to OVER.
  - Else if all 9 cells are full, set gameover[8]=1, gameover[9]=1, winner=00, go to OVER.
  - Else toggle turn, clear the timer, return to PLAY.
- Latency: accept edge N → board bit visible at N+1 → gameover/turn updated at N+2 → move_ready high again at N+2.
- OVER:
  - move_ready=0.
  - Board, gameover and winner are held.
  - move_valid is ignored; no move_err is raised.
- Turn timer:
  - Counts only in PLAY when TURN_TIMEOUT!=0.
  - On reaching TURN_TIMEOUT-1 with no accepted move: timeout pulse, turn toggles, timer clears.
  - An accepted move in the same cycle takes priority over timeout (no pulse).
- new_game:
  - Sampled in any state and has priority over a move in the same cycle.
  - Clears board, gameover, winner and timer; enters PLAY.
  - turn = opposite of the side that started the previous game, so the first mover alternates between games. After reset, X starts.
- move_err and timeout are registered outputs and never assert together.

Decomposition:
- Package ttt_pkg holds:
  - State enum (PLAY, CHECK, OVER).
  - Gameover bit indices (GO_ROW0..GO_DIAG1, GO_DRAW, GO_OVER).
  - LINE_MASK[8] constants as 9-bit cell masks.
  - Function addr_to_idx(addr)→row*3+col and function addr_legal(addr).
- Sub-module ttt_line_eval (combinational):
  - Inputs: 9-bit bitmap.
  - Outputs: 8-bit line-complete vector and a full flag.
  - Used once in the CHECK state.

Test Plan:
- Reset, then X plays 0, O plays 4, X 1, O 5, X 2 → two cycles after the last accept, gameover=10'h201, winner=01, move_ready=0, board_x=9'h007.
- Occupied/illegal cell: X plays 5; O offers 5, then 3, then B → move_err pulses 3×, turn stays 1, board_o=0.
- Draw sequence X0,O1,X2,O4,X3,O5,X7,O6,X8 → gameover=10'h300, winner=00.
- Double line: final X move at 4 completes column 1 and the diagonal → gameover=10'h250, winner=01.
- TURN_TIMEOUT=8: no move for 8 cycles → timeout pulse, turn 0→1. A move accepted in cycle 8 instead → no pulse.
- In OVER, assert new_game together with move_valid → board cleared, gameover=0, turn=1, move ignored. Assert rst_n=0 mid-CHECK → all outputs 0 immediately.
